// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Cache-to-memory arbitration types: arbiter state encoding and
//               the identity of the last side granted the RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_D    = 2'd1,
        ARB_I    = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU-side types: the RAM status code reported by the
//               memory model/controller and the basic machine word.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    localparam int c_WORD_W = 32;

    typedef logic [c_WORD_W-1:0] word_t;

    // Status presented by the RAM on ramstate.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Responder side of the cache-to-memory protocol. Arbitrates
//               the icache and dcache onto one shared, variable-latency RAM
//               port. A grant is held until the RAM reports ACCESS or the
//               granted requester withdraws; one idle cycle separates grants.
//
// Ports       : CLK, RST            clock, asynchronous active-high reset
//               iREN/iaddr          instruction read request
//               iwait/iload         instruction completion / read data
//               dREN/dWEN/daddr/dstore  data read/write request
//               dwait/dload         data completion / read data
//               ramREN/ramWEN/ramaddr/ramstore  RAM request
//               ramload/ramstate    RAM read data / status
//
// Build macro : ARB_RR_EN - when defined, simultaneous requests in idle are
//               granted round-robin against the last completed side; when
//               undefined the data side always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import cpu_types_pkg::*;
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    // icache side
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    // dcache side
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    // RAM side
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       w_dreq;
    logic       w_access;
    logic       w_pick_d;

    assign w_dreq   = dREN | dWEN;
    // BUSY, ERROR and FREE all mean "not done yet": the strobes are simply
    // held so the RAM retries the same access.
    assign w_access = (ramstate_t'(ramstate) == ACCESS);

`ifdef ARB_RR_EN
    // Remembers which side completed last so that, with both sides pending
    // in idle, the other side is served next.
    grant_t r_last_grant;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last_grant <= GRANT_I;
        end else if ((r_state == ARB_D) && w_dreq && w_access) begin
            r_last_grant <= GRANT_D;
        end else if ((r_state == ARB_I) && iREN && w_access) begin
            r_last_grant <= GRANT_I;
        end
    end

    assign w_pick_d = (r_last_grant == GRANT_I);
`else
    assign w_pick_d = 1'b1;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs are a pure function of the granted side and the live inputs;
    // whoever is not granted sees wait=1/load=0 even if ACCESS shows up.
    always_comb begin
        w_next_state = r_state;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = '0;
        dload        = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;

        case (r_state)
            ARB_IDLE: begin
                if (w_dreq && (w_pick_d || !iREN)) begin
                    w_next_state = ARB_D;
                end else if (iREN) begin
                    w_next_state = ARB_I;
                end
            end

            ARB_D: begin
                if (w_dreq) begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    // A simultaneous read and write is treated as a write.
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (w_access) begin
                        dwait        = 1'b0;
                        dload        = dWEN ? '0 : ramload;
                        w_next_state = ARB_IDLE;
                    end
                end else begin
                    // Request withdrawn: drop the strobes and release.
                    w_next_state = ARB_IDLE;
                end
            end

            ARB_I: begin
                if (iREN) begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (w_access) begin
                        iwait        = 1'b0;
                        iload        = ramload;
                        w_next_state = ARB_IDLE;
                    end
                end else begin
                    w_next_state = ARB_IDLE;
                end
            end

            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
